// File: rtl/svc_rv_perf_mon.sv
// Performance monitor: counts cycles, retired instructions and generic events
// between start and ebreak, with shadow snapshots and sticky saturation flags.
module svc_rv_perf_mon #(
    parameter int unsigned NUM_EVENTS = 4,
    parameter int unsigned CNT_WIDTH  = 32,
    localparam int unsigned AW        = $clog2(NUM_EVENTS + 2)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      retire,
    input  logic                      ebreak,
    input  logic [NUM_EVENTS-1:0]     evt,
    input  logic                      snap,
    input  logic [AW-1:0]             rd_addr,
    output logic [CNT_WIDTH-1:0]      rd_data,
    output logic                      running,
    output logic                      halted,
    output logic                      snap_valid,
    output logic [NUM_EVENTS+1:0]     ovf
);

    localparam int unsigned NC = NUM_EVENTS + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt     [NC];
    logic [CNT_WIDTH-1:0] cnt_nxt [NC];
    logic [CNT_WIDTH-1:0] shadow  [NC];
    logic [NC-1:0]        inc_en;
    logic [NC-1:0]        sat;

    // Saturating post-increment values for the current cycle
    always_comb begin
        inc_en    = '0;
        inc_en[0] = (state == ST_RUN);
        inc_en[1] = (state == ST_RUN) && retire;
        for (int i = 0; i < int'(NUM_EVENTS); i++) begin
            inc_en[i+2] = (state == ST_RUN) && evt[i];
        end
        for (int i = 0; i < int'(NC); i++) begin
            sat[i]     = inc_en[i] && (&cnt[i]);
            cnt_nxt[i] = (inc_en[i] && !(&cnt[i])) ? cnt[i] + CNT_WIDTH'(1) : cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            running    <= 1'b0;
            halted     <= 1'b0;
            snap_valid <= 1'b0;
            ovf        <= '0;
            for (int i = 0; i < int'(NC); i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else if (clear) begin
            state      <= ST_IDLE;
            running    <= 1'b0;
            halted     <= 1'b0;
            snap_valid <= 1'b0;
            ovf        <= '0;
            for (int i = 0; i < int'(NC); i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (snap) begin
                        snap_valid <= 1'b1;
                        for (int i = 0; i < int'(NC); i++) shadow[i] <= cnt[i];
                    end
                    if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ovf <= ovf | sat;
                    for (int i = 0; i < int'(NC); i++) cnt[i] <= cnt_nxt[i];
                    // ebreak and snap share one snapshot of the including-this-cycle values
                    if (ebreak || snap) begin
                        snap_valid <= 1'b1;
                        for (int i = 0; i < int'(NC); i++) shadow[i] <= cnt_nxt[i];
                    end
                    if (ebreak) begin
                        state   <= ST_HALT;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (snap) begin
                        snap_valid <= 1'b1;
                        for (int i = 0; i < int'(NC); i++) shadow[i] <= cnt[i];
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow read mux; out-of-range addresses read as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(NC); i++) begin
            if (rd_addr == AW'(i)) rd_data = shadow[i];
        end
    end

endmodule
